lsu_mem: RTL and testbench

- Memory-access stage directly downstream of the execute stage.
- Consumes the execute stage's memory address, store data, load/store valid flag and type, and rd write-back fields.
- Runs a request/response handshake on the data-memory port and formats load data by byte lane and sign.
- Returns the final rd write data, which doubles as the LS-stage forwarding source, and raises a pipeline stall while an access is outstanding.

---
 rtl/lsu_mem.sv | 181 ++++++++++++++++++
 tb/tb_lsu_mem.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem.sv
// rtl/lsu_mem.sv - memory-access stage: dmem request/response handshake and load formatting.
// Optional misaligned-access trapping is enabled by defining LSU_MISALIGN_CHECK_EN.
module lsu_mem #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       I_inst_addr,
    input  logic              I_rd_we,
    input  logic [4:0]        I_rd_waddr,
    input  logic [31:0]       I_rd_wdata,
    input  logic [ADDR_W-1:0] I_memory_addr,
    input  logic [DATA_W-1:0] I_store_data,
    input  logic              I_ls_valid,
    input  logic [3:0]        I_ls_type,
    output logic [31:0]       O_inst_addr,
    output logic              O_rd_we,
    output logic [4:0]        O_rd_waddr,
    output logic [31:0]       O_rd_wdata,
    output logic              O_stallreq,
    output logic              O_except_misalign,
    output logic              O_dmem_req,
    output logic              O_dmem_we,
    output logic [ADDR_W-1:0] O_dmem_addr,
    output logic [DATA_W-1:0] O_dmem_wdata,
    output logic [3:0]        O_dmem_wstrb,
    input  logic              I_dmem_ready,
    input  logic              I_dmem_rvalid,
    input  logic [DATA_W-1:0] I_dmem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        off_q;
    logic [3:0]        type_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        wstrb_q;
    logic [DATA_W-1:0] load_buf;

    logic [1:0]        off;
    logic              trap;
    logic              start;
    logic              capture;
    logic [3:0]        strb;
    logic [DATA_W-1:0] store_rep;
    logic [7:0]        sel_b;
    logic [15:0]       sel_h;
    logic [31:0]       load_fmt;

    assign off = I_memory_addr[1:0];

`ifdef LSU_MISALIGN_CHECK_EN
    always_comb begin
        trap = 1'b0;
        if (I_ls_valid && state == IDLE) begin
            case (I_ls_type[1:0])
                2'b01:   trap = off[0];
                2'b00:   trap = 1'b0;
                default: trap = (off != 2'b00);
            endcase
        end
    end
`else
    assign trap = 1'b0;
`endif

    assign O_except_misalign = trap;
    assign start = (state == IDLE) && I_ls_valid && !trap;

    // Half accesses use only off[1]; word accesses ignore the offset entirely.
    always_comb begin
        strb      = 4'b0000;
        store_rep = I_store_data;
        case (I_ls_type[1:0])
            2'b00: begin
                strb      = 4'b0001 << off;
                store_rep = {4{I_store_data[7:0]}};
            end
            2'b01: begin
                strb      = 4'b0011 << {off[1], 1'b0};
                store_rep = {2{I_store_data[15:0]}};
            end
            default: begin
                strb      = 4'b1111;
                store_rep = I_store_data;
            end
        endcase
        if (!I_ls_type[3]) strb = 4'b0000;
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = REQ;
            REQ: begin
                if (I_dmem_ready) begin
                    if (we_q) begin
                        state_nxt = DONE;
                    end else if (I_dmem_rvalid) begin
                        capture   = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = RESP;
                    end
                end
            end
            RESP: begin
                if (I_dmem_rvalid) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            off_q    <= '0;
            type_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            load_buf <= '0;
        end else begin
            state <= state_nxt;
            if (start) begin
                addr_q  <= {I_memory_addr[ADDR_W-1:2], 2'b00};
                off_q   <= off;
                type_q  <= I_ls_type;
                we_q    <= I_ls_type[3];
                wdata_q <= store_rep;
                wstrb_q <= strb;
            end
            if (capture) load_buf <= I_dmem_rdata;
        end
    end

    always_comb begin
        sel_b = load_buf[7:0];
        case (off_q)
            2'b00: sel_b = load_buf[7:0];
            2'b01: sel_b = load_buf[15:8];
            2'b10: sel_b = load_buf[23:16];
            default: sel_b = load_buf[31:24];
        endcase
        sel_h = off_q[1] ? load_buf[31:16] : load_buf[15:0];
        case (type_q[1:0])
            2'b00:   load_fmt = {{24{sel_b[7] & ~type_q[2]}}, sel_b};
            2'b01:   load_fmt = {{16{sel_h[15] & ~type_q[2]}}, sel_h};
            default: load_fmt = load_buf;
        endcase
    end

    assign O_stallreq   = start || (state == REQ) || (state == RESP);
    assign O_dmem_req   = (state == REQ);
    assign O_dmem_we    = (state == REQ) && we_q;
    assign O_dmem_addr  = addr_q;
    assign O_dmem_wdata = wdata_q;
    assign O_dmem_wstrb = (state == REQ) ? wstrb_q : 4'b0000;

    assign O_inst_addr = I_inst_addr;
    assign O_rd_waddr  = I_rd_waddr;
    // A load's result only becomes visible in DONE, when the buffer holds the returned word.
    assign O_rd_wdata  = (state == DONE && !type_q[3]) ? load_fmt : I_rd_wdata;
    assign O_rd_we     = I_rd_we && !O_stallreq && !trap;

endmodule

// File: tb/tb_lsu_mem.sv
// tb/tb_lsu_mem.sv - directed self-checking bench for lsu_mem.
module tb_lsu_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] I_inst_addr;
    logic        I_rd_we;
    logic [4:0]  I_rd_waddr;
    logic [31:0] I_rd_wdata;
    logic [31:0] I_memory_addr;
    logic [31:0] I_store_data;
    logic        I_ls_valid;
    logic [3:0]  I_ls_type;
    logic [31:0] O_inst_addr;
    logic        O_rd_we;
    logic [4:0]  O_rd_waddr;
    logic [31:0] O_rd_wdata;
    logic        O_stallreq;
    logic        O_except_misalign;
    logic        O_dmem_req;
    logic        O_dmem_we;
    logic [31:0] O_dmem_addr;
    logic [31:0] O_dmem_wdata;
    logic [3:0]  O_dmem_wstrb;
    logic        I_dmem_ready;
    logic        I_dmem_rvalid;
    logic [31:0] I_dmem_rdata;

    int checks = 0;
    int errors = 0;

    lsu_mem dut (
        .clk(clk), .rst(rst),
        .I_inst_addr(I_inst_addr), .I_rd_we(I_rd_we), .I_rd_waddr(I_rd_waddr),
        .I_rd_wdata(I_rd_wdata), .I_memory_addr(I_memory_addr), .I_store_data(I_store_data),
        .I_ls_valid(I_ls_valid), .I_ls_type(I_ls_type),
        .O_inst_addr(O_inst_addr), .O_rd_we(O_rd_we), .O_rd_waddr(O_rd_waddr),
        .O_rd_wdata(O_rd_wdata), .O_stallreq(O_stallreq), .O_except_misalign(O_except_misalign),
        .O_dmem_req(O_dmem_req), .O_dmem_we(O_dmem_we), .O_dmem_addr(O_dmem_addr),
        .O_dmem_wdata(O_dmem_wdata), .O_dmem_wstrb(O_dmem_wstrb),
        .I_dmem_ready(I_dmem_ready), .I_dmem_rvalid(I_dmem_rvalid), .I_dmem_rdata(I_dmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] typ, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic rd_we);
        I_ls_valid    = 1'b1;
        I_ls_type     = typ;
        I_memory_addr = addr;
        I_store_data  = sdata;
        I_rd_we       = rd_we;
        I_rd_wdata    = 32'h0000_0000;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        I_inst_addr = 32'h0000_1000; I_rd_we = 1'b0; I_rd_waddr = 5'd3; I_rd_wdata = '0;
        I_memory_addr = '0; I_store_data = '0; I_ls_valid = 1'b0; I_ls_type = '0;
        I_dmem_ready = 1'b0; I_dmem_rvalid = 1'b0; I_dmem_rdata = '0;
        tick();
        check("rst_req", {31'd0, O_dmem_req}, 32'd0);
        check("rst_we", {31'd0, O_dmem_we}, 32'd0);
        check("rst_wstrb", {28'd0, O_dmem_wstrb}, 32'd0);
        check("rst_stall", {31'd0, O_stallreq}, 32'd0);
        check("rst_addr", O_dmem_addr, 32'd0);
        rst = 1'b0;
        tick();

        // SW 0x8000_0004, ready after 2 REQ cycles
        issue(4'b1010, 32'h8000_0004, 32'hDEAD_BEEF, 1'b0);
        check("sw_stall_idle", {31'd0, O_stallreq}, 32'd1);
        check("sw_req_idle", {31'd0, O_dmem_req}, 32'd0);
        tick();
        check("sw_req1", {31'd0, O_dmem_req}, 32'd1);
        check("sw_we", {31'd0, O_dmem_we}, 32'd1);
        check("sw_wstrb", {28'd0, O_dmem_wstrb}, 32'hF);
        check("sw_addr", O_dmem_addr, 32'h8000_0004);
        check("sw_wdata", O_dmem_wdata, 32'hDEAD_BEEF);
        check("sw_stall1", {31'd0, O_stallreq}, 32'd1);
        tick();
        I_dmem_ready = 1'b1;
        #1;
        check("sw_req2", {31'd0, O_dmem_req}, 32'd1);
        check("sw_stall2", {31'd0, O_stallreq}, 32'd1);
        tick();
        I_dmem_ready = 1'b0;
        #1;
        check("sw_done_stall", {31'd0, O_stallreq}, 32'd0);
        check("sw_done_req", {31'd0, O_dmem_req}, 32'd0);
        check("sw_done_rdwe", {31'd0, O_rd_we}, 32'd0);
        I_ls_valid = 1'b0;
        tick();

        // LB 0x8000_0003, ready then rvalid a cycle later
        issue(4'b0000, 32'h8000_0003, 32'h0, 1'b1);
        check("lb_rdwe_stalled", {31'd0, O_rd_we}, 32'd0);
        tick();
        check("lb_wstrb", {28'd0, O_dmem_wstrb}, 32'd0);
        check("lb_addr", O_dmem_addr, 32'h8000_0000);
        check("lb_we", {31'd0, O_dmem_we}, 32'd0);
        I_dmem_ready = 1'b1;
        tick();
        I_dmem_ready = 1'b0; I_dmem_rvalid = 1'b1; I_dmem_rdata = 32'h8000_0000;
        #1;
        check("lb_resp_stall", {31'd0, O_stallreq}, 32'd1);
        check("lb_resp_req", {31'd0, O_dmem_req}, 32'd0);
        tick();
        I_dmem_rvalid = 1'b0;
        #1;
        check("lb_data", O_rd_wdata, 32'hFFFF_FF80);
        check("lb_rdwe", {31'd0, O_rd_we}, 32'd1);
        check("lb_stall", {31'd0, O_stallreq}, 32'd0);
        I_ls_valid = 1'b0;
        tick();

        // LBU same access
        issue(4'b0100, 32'h8000_0003, 32'h0, 1'b1);
        tick();
        I_dmem_ready = 1'b1;
        tick();
        I_dmem_ready = 1'b0; I_dmem_rvalid = 1'b1; I_dmem_rdata = 32'h8000_0000;
        tick();
        I_dmem_rvalid = 1'b0;
        #1;
        check("lbu_data", O_rd_wdata, 32'h0000_0080);
        I_ls_valid = 1'b0;
        tick();

        // SH 0x102, single-cycle ready
        issue(4'b1001, 32'h0000_0102, 32'h0000_1234, 1'b0);
        tick();
        check("sh_wstrb", {28'd0, O_dmem_wstrb}, 32'hC);
        check("sh_wdata", O_dmem_wdata, 32'h1234_1234);
        check("sh_addr", O_dmem_addr, 32'h0000_0100);
        I_dmem_ready = 1'b1;
        tick();
        I_dmem_ready = 1'b0;
        #1;
        check("sh_done_stall", {31'd0, O_stallreq}, 32'd0);
        I_ls_valid = 1'b0;
        tick();

        // SB 0x101 -> lane 1
        issue(4'b1000, 32'h0000_0101, 32'h0000_00A5, 1'b0);
        tick();
        check("sb_wstrb", {28'd0, O_dmem_wstrb}, 32'h2);
        check("sb_wdata", O_dmem_wdata, 32'hA5A5_A5A5);
        I_dmem_ready = 1'b1;
        tick();
        I_dmem_ready = 1'b0;
        I_ls_valid = 1'b0;
        tick();

        // LH 0x202, negative upper half
        issue(4'b0001, 32'h0000_0202, 32'h0, 1'b1);
        tick();
        I_dmem_ready = 1'b1; I_dmem_rvalid = 1'b1; I_dmem_rdata = 32'h8001_7FFF;
        tick();
        I_dmem_ready = 1'b0; I_dmem_rvalid = 1'b0;
        #1;
        check("lh_data", O_rd_wdata, 32'hFFFF_8001);
        I_ls_valid = 1'b0;
        tick();

        // LW with ready+rvalid together: stall 2 cycles
        issue(4'b0010, 32'h0000_0040, 32'h0, 1'b1);
        check("lw_stall_idle", {31'd0, O_stallreq}, 32'd1);
        tick();
        I_dmem_ready = 1'b1; I_dmem_rvalid = 1'b1; I_dmem_rdata = 32'hCAFE_F00D;
        #1;
        check("lw_stall_req", {31'd0, O_stallreq}, 32'd1);
        tick();
        I_dmem_ready = 1'b0; I_dmem_rvalid = 1'b0;
        #1;
        check("lw_done_stall", {31'd0, O_stallreq}, 32'd0);
        check("lw_data", O_rd_wdata, 32'hCAFE_F00D);
        check("lw_rdwe", {31'd0, O_rd_we}, 32'd1);
        I_ls_valid = 1'b0;
        tick();

        // Non-memory instruction passes through combinationally
        I_ls_valid = 1'b0; I_rd_we = 1'b1; I_rd_wdata = 32'h0000_0055; I_rd_waddr = 5'd9;
        I_inst_addr = 32'h0000_2000;
        #1;
        check("nm_data", O_rd_wdata, 32'h0000_0055);
        check("nm_rdwe", {31'd0, O_rd_we}, 32'd1);
        check("nm_stall", {31'd0, O_stallreq}, 32'd0);
        check("nm_waddr", {27'd0, O_rd_waddr}, 32'd9);
        check("nm_pc", O_inst_addr, 32'h0000_2000);
        tick();

        // Reset asserted during RESP
        issue(4'b0010, 32'h0000_0080, 32'h0, 1'b1);
        tick();
        I_dmem_ready = 1'b1;
        tick();
        I_dmem_ready = 1'b0;
        #1;
        check("rr_resp_stall", {31'd0, O_stallreq}, 32'd1);
        I_ls_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rr_req", {31'd0, O_dmem_req}, 32'd0);
        check("rr_stall", {31'd0, O_stallreq}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        I_dmem_rvalid = 1'b1; I_dmem_rdata = 32'h1111_1111;
        #1;
        check("rr_rvalid_ignored", {31'd0, O_stallreq}, 32'd0);
        tick();
        I_dmem_rvalid = 1'b0;

        // LW at 0x2: trapped when checking is enabled, issued at 0x0 otherwise
        issue(4'b0010, 32'h0000_0002, 32'h0, 1'b1);
`ifdef LSU_MISALIGN_CHECK_EN
        check("mis_except", {31'd0, O_except_misalign}, 32'd1);
        check("mis_stall", {31'd0, O_stallreq}, 32'd0);
        check("mis_rdwe", {31'd0, O_rd_we}, 32'd0);
        tick();
        check("mis_req", {31'd0, O_dmem_req}, 32'd0);
        I_ls_valid = 1'b0;
        tick();
`else
        check("mis_except", {31'd0, O_except_misalign}, 32'd0);
        check("mis_stall", {31'd0, O_stallreq}, 32'd1);
        tick();
        check("mis_req", {31'd0, O_dmem_req}, 32'd1);
        check("mis_addr", O_dmem_addr, 32'h0000_0000);
        I_dmem_ready = 1'b1; I_dmem_rvalid = 1'b1; I_dmem_rdata = 32'h0BAD_F00D;
        tick();
        I_dmem_ready = 1'b0; I_dmem_rvalid = 1'b0;
        #1;
        check("mis_data", O_rd_wdata, 32'h0BAD_F00D);
        I_ls_valid = 1'b0;
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
